microsequencer_gen2: RTL and testbench
======================================

MICROSEQUENCER_GEN2 -- requirements
Module: microsequencer_gen2

Interface
REQ-001 Parameter ADDR_W, default 6, control-store address width; legal values are ADDR_W >= 6.
REQ-002 Parameter STACK_DEPTH, default 4, number of micro-call return entries; legal values are 2..16.
REQ-003 Parameter RESET_VEC, default 18, the micro-address loaded at reset and on stack underflow.
REQ-004 Parameter DISPATCH_BASE, default 0, ADDR_W-bit value ORed into every IRD dispatch address.
REQ-005 Clock and reset are fixed: one clock; reset is synchronous and active-low.
REQ-006 Port i_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port i_RST_N, input, 1 bit: synchronous, active-low reset.
REQ-008 Port i_STALL, input, 1 bit: when high, holds all state (memory wait).
REQ-009 Port i_SEQ_op, input, 2 bits: 00 BRANCH, 01 IRD, 10 CALL, 11 RET.
REQ-010 Port i_j_field, input, ADDR_W bits: base or target micro-address.
REQ-011 Port i_ret_field, input, ADDR_W bits: return address pushed by CALL.
REQ-012 Port i_COND_bits, input, 3 bits: branch condition select.
REQ-013 Port i_LD_BEN, input, 1 bit: loads the BEN register.
REQ-014 Port i_R_Bit, input, 1 bit: memory ready.
REQ-015 Port i_IR_15_9, input, 7 bits: IR[15:9].
REQ-016 Port i_NZP, input, 3 bits: condition codes N, Z, P.
REQ-017 Port i_ACV, input, 1 bit: access violation.
REQ-018 Port i_PSR_15, input, 1 bit: privilege bit.
REQ-019 Port i_INT, input, 1 bit: interrupt request.
REQ-020 Port o_uPC, output, ADDR_W bits: registered current micro-address.
REQ-021 Port o_AddressNextState, output, ADDR_W bits: combinational next micro-address.
REQ-022 Port o_stack_depth, output, 5 bits: current number of stack entries.
REQ-023 Port o_stack_err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-024 BRANCH SHALL form o_AddressNextState as i_j_field ORed with one condition bit: ACV(110) at bit 5, INT(101) at bit 4, PSR15(100) at bit 3, BEN(010) at bit 2, R(001) at bit 1, IR[11](011) at bit 0; select 000 and 111 SHALL OR nothing.
REQ-025 IRD SHALL form o_AddressNextState as zero-extended IR[15:12] ORed with DISPATCH_BASE, ignoring i_COND_bits.
REQ-026 CALL SHALL form o_AddressNextState as i_j_field and, at the clock edge, push i_ret_field.
REQ-027 RET SHALL form o_AddressNextState as the top-of-stack entry and, at the clock edge, pop it.
REQ-028 The BEN register SHALL load (IR[11]&N)|(IR[10]&Z)|(IR[9]&P) at the clock edge when i_LD_BEN=1 and i_STALL=0; branch selection SHALL use the registered BEN, not the live value.
REQ-029 o_uPC SHALL load o_AddressNextState at each clock edge where i_STALL=0; next-state latency is one cycle.
REQ-030 While i_STALL=1, o_uPC, BEN, the stack, and o_stack_err SHALL hold; o_AddressNextState SHALL still track the inputs.
REQ-031 A CALL with depth=STACK_DEPTH SHALL jump to i_j_field, drop the push, and set o_stack_err.
REQ-032 A RET with depth=0 SHALL drive RESET_VEC on o_AddressNextState and set o_stack_err; depth SHALL stay 0.
REQ-033 o_stack_err SHALL remain set until reset.

Reset
REQ-034 When i_RST_N=0 at a clock edge: o_uPC=RESET_VEC, BEN=0, depth=0, o_stack_err=0; reset SHALL override i_STALL and any in-flight CALL or RET.

Configuration
REQ-035 Macro MICROSEQ_CALL_STACK_EN defined: REQ-026/027/031/032 SHALL apply.
REQ-036 Macro MICROSEQ_CALL_STACK_EN undefined: CALL and RET SHALL behave as BRANCH, no stack storage SHALL exist, and o_stack_depth and o_stack_err SHALL be tied to 0.

Verification
REQ-037 Scenario 1: Reset, then idle -> o_uPC=18, o_stack_depth=0, o_stack_err=0.
REQ-038 Scenario 2: IR_15_9=7'b0000_111, NZP=3'b010, LD_BEN=1; next cycle BRANCH, COND=010, j=0 -> next state 4.
REQ-039 Scenario 3: IRD with IR[15:12]=4'b1100 and DISPATCH_BASE=0 -> next state 12; BRANCH, COND=110, j=3, ACV=1 -> next state 35.
REQ-040 Scenario 4: CALL j=40, ret=7; then CALL j=50, ret=9; then RET; then RET -> uPC sequence 40, 50, 9, 7; depth sequence 1, 2, 1, 0.
REQ-041 Scenario 5: Five CALLs at depth 4 -> o_stack_err=1 and depth=4; RET at depth 0 -> uPC=18 and o_stack_err=1.
REQ-042 Scenario 6: STALL=1 for 3 cycles during a CALL -> uPC and depth unchanged; i_RST_N=0 while STALL=1 -> uPC=18.

Source files
------------

// File: rtl/microsequencer_gen2.sv
// Microsequencer: registered uPC with BRANCH / IRD dispatch and an optional micro-call stack.
// Define MICROSEQ_CALL_STACK_EN to build the CALL/RET stack; otherwise CALL and RET act as BRANCH.
module microsequencer_gen2 #(
    parameter int ADDR_W        = 6,
    parameter int STACK_DEPTH   = 4,
    parameter int RESET_VEC     = 18,
    parameter int DISPATCH_BASE = 0
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_STALL,
    input  logic [1:0]        i_SEQ_op,
    input  logic [ADDR_W-1:0] i_j_field,
    input  logic [ADDR_W-1:0] i_ret_field,
    input  logic [2:0]        i_COND_bits,
    input  logic              i_LD_BEN,
    input  logic              i_R_Bit,
    input  logic [6:0]        i_IR_15_9,
    input  logic [2:0]        i_NZP,
    input  logic              i_ACV,
    input  logic              i_PSR_15,
    input  logic              i_INT,
    output logic [ADDR_W-1:0] o_uPC,
    output logic [ADDR_W-1:0] o_AddressNextState,
    output logic [4:0]        o_stack_depth,
    output logic              o_stack_err
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] DISP_BASE  = ADDR_W'(DISPATCH_BASE);

    typedef enum logic [1:0] {
        OP_BRANCH = 2'b00,
        OP_IRD    = 2'b01,
        OP_CALL   = 2'b10,
        OP_RET    = 2'b11
    } seq_op_t;

    seq_op_t           op;
    logic              ben;
    logic [ADDR_W-1:0] cond_or;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] ird_addr;

    assign op = seq_op_t'(i_SEQ_op);

    // Each condition select lights exactly one address bit; BEN is the registered copy.
    always_comb begin
        cond_or = '0;
        case (i_COND_bits)
            3'b001:  cond_or[1] = i_R_Bit;
            3'b010:  cond_or[2] = ben;
            3'b011:  cond_or[0] = i_IR_15_9[2];
            3'b100:  cond_or[3] = i_PSR_15;
            3'b101:  cond_or[4] = i_INT;
            3'b110:  cond_or[5] = i_ACV;
            default: cond_or    = '0;
        endcase
    end

    assign branch_addr = i_j_field | cond_or;
    assign ird_addr    = {{(ADDR_W-4){1'b0}}, i_IR_15_9[6:3]} | DISP_BASE;

`ifdef MICROSEQ_CALL_STACK_EN
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [4:0]        depth;
    logic [4:0]        top;
    logic              err;
    logic              push, pop, fault;

    assign top = depth - 5'd1;

    always_comb begin
        o_AddressNextState = branch_addr;
        push  = 1'b0;
        pop   = 1'b0;
        fault = 1'b0;
        case (op)
            OP_IRD: o_AddressNextState = ird_addr;
            OP_CALL: begin
                o_AddressNextState = i_j_field;
                if (depth == 5'(STACK_DEPTH)) fault = 1'b1;
                else                          push  = 1'b1;
            end
            OP_RET: begin
                if (depth == 5'd0) begin
                    o_AddressNextState = RESET_ADDR;
                    fault = 1'b1;
                end else begin
                    o_AddressNextState = stack[top[PW-1:0]];
                    pop = 1'b1;
                end
            end
            default: o_AddressNextState = branch_addr;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            depth <= '0;
            err   <= 1'b0;
        end else if (!i_STALL) begin
            if (push)      depth <= depth + 5'd1;
            else if (pop)  depth <= top;
            if (fault)     err   <= 1'b1;
        end
    end

    // Entries need no reset: depth gates every read.
    always_ff @(posedge i_CLK) begin
        if (i_RST_N && !i_STALL && push)
            stack[depth[PW-1:0]] <= i_ret_field;
    end

    assign o_stack_depth = depth;
    assign o_stack_err   = err;
`else
    logic unused_ret;

    assign unused_ret         = ^i_ret_field;
    assign o_AddressNextState = (op == OP_IRD) ? ird_addr : branch_addr;
    assign o_stack_depth      = 5'd0;
    assign o_stack_err        = 1'b0;
`endif

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            o_uPC <= RESET_ADDR;
            ben   <= 1'b0;
        end else if (!i_STALL) begin
            o_uPC <= o_AddressNextState;
            if (i_LD_BEN)
                ben <= (i_IR_15_9[2] & i_NZP[2]) | (i_IR_15_9[1] & i_NZP[1]) |
                       (i_IR_15_9[0] & i_NZP[0]);
        end
    end

endmodule

// File: tb/tb_microsequencer_gen2.sv
// Directed + randomized bench for microsequencer_gen2 against a queue-based reference model.
// Stack expectations follow MICROSEQ_CALL_STACK_EN exactly as the RTL build does.
module tb_microsequencer_gen2;

    localparam int AW = 6;
    localparam int SD = 4;
    localparam int RV = 18;

    logic          i_CLK = 1'b0;
    logic          i_RST_N, i_STALL, i_LD_BEN, i_R_Bit, i_ACV, i_PSR_15, i_INT;
    logic [1:0]    i_SEQ_op;
    logic [AW-1:0] i_j_field, i_ret_field;
    logic [2:0]    i_COND_bits, i_NZP;
    logic [6:0]    i_IR_15_9;
    logic [AW-1:0] o_uPC, o_AddressNextState;
    logic [4:0]    o_stack_depth;
    logic          o_stack_err;

    microsequencer_gen2 #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_VEC(RV), .DISPATCH_BASE(0)) dut (
        .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_STALL(i_STALL), .i_SEQ_op(i_SEQ_op),
        .i_j_field(i_j_field), .i_ret_field(i_ret_field), .i_COND_bits(i_COND_bits),
        .i_LD_BEN(i_LD_BEN), .i_R_Bit(i_R_Bit), .i_IR_15_9(i_IR_15_9), .i_NZP(i_NZP),
        .i_ACV(i_ACV), .i_PSR_15(i_PSR_15), .i_INT(i_INT), .o_uPC(o_uPC),
        .o_AddressNextState(o_AddressNextState), .o_stack_depth(o_stack_depth),
        .o_stack_err(o_stack_err)
    );

    always #5 i_CLK = ~i_CLK;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int m_upc;
    bit m_ben;
    bit m_err;
    int m_stk[$];
    int m_next;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Next address from the rules: which input feeds which bit, stack as a queue.
    function automatic int model_next(output bit push, output bit pop, output bit fault);
        int sh[8]  = '{-1, 1, 2, 0, 3, 4, 5, -1};
        bit src[8] = '{1'b0, i_R_Bit, m_ben, i_IR_15_9[2], i_PSR_15, i_INT, i_ACV, 1'b0};
        int br     = int'(i_j_field) | ((src[i_COND_bits]) ? (1 << sh[i_COND_bits]) : 0);
        push = 0; pop = 0; fault = 0;
        if (i_SEQ_op == 2'b01) return int'(i_IR_15_9) / 8;
`ifdef MICROSEQ_CALL_STACK_EN
        if (i_SEQ_op == 2'b10) begin
            if (m_stk.size() == SD) fault = 1; else push = 1;
            return int'(i_j_field);
        end
        if (i_SEQ_op == 2'b11) begin
            if (m_stk.size() == 0) begin fault = 1; return RV; end
            pop = 1;
            return m_stk[$];
        end
`endif
        return br;
    endfunction

    // One cycle: inputs already driven after a negedge.
    task automatic step(input string tag);
        bit push, pop, fault;
        #1;
        m_next = model_next(push, pop, fault);
        chk({tag, ".next"}, 32'(o_AddressNextState), 32'(m_next));
        @(posedge i_CLK);
        if (!i_RST_N) begin
            m_upc = RV; m_ben = 0; m_err = 0; m_stk.delete();
        end else if (!i_STALL) begin
            m_upc = m_next;
            if (i_LD_BEN) m_ben = ((i_IR_15_9[2:0] & i_NZP) != 3'b000);
            if (push) m_stk.push_back(int'(i_ret_field));
            if (pop) void'(m_stk.pop_back());
            if (fault) m_err = 1;
        end
        #1;
        chk({tag, ".upc"}, 32'(o_uPC), 32'(m_upc));
        chk({tag, ".depth"}, 32'(o_stack_depth), 32'(m_stk.size()));
        chk({tag, ".err"}, 32'(o_stack_err), 32'(m_err));
        @(negedge i_CLK);
    endtask

    task automatic idle();
        i_RST_N = 1; i_STALL = 0; i_SEQ_op = 2'b00; i_j_field = '0; i_ret_field = '0;
        i_COND_bits = 3'b000; i_LD_BEN = 0; i_R_Bit = 0; i_IR_15_9 = '0; i_NZP = '0;
        i_ACV = 0; i_PSR_15 = 0; i_INT = 0;
    endtask

    task automatic call(input int j, input int r);
        i_SEQ_op = 2'b10; i_j_field = AW'(j); i_ret_field = AW'(r); step("call");
    endtask

    task automatic ret();
        i_SEQ_op = 2'b11; step("ret");
    endtask

    initial begin
        m_upc = 0; m_ben = 0; m_err = 0;
        idle();
        @(negedge i_CLK);

        // Scenario 1: reset then idle
        i_RST_N = 0; step("rst");
        i_RST_N = 1; i_COND_bits = 3'b000; i_j_field = AW'(RV); step("idle");
        chk("s1.upc", 32'(o_uPC), 32'(RV));
        chk("s1.depth", 32'(o_stack_depth), 0);
        chk("s1.err", 32'(o_stack_err), 0);

        // Scenario 2: BEN loads, then a BEN branch uses the registered copy
        i_IR_15_9 = 7'b0000_111; i_NZP = 3'b010; i_LD_BEN = 1; i_j_field = '0; step("s2.ld");
        i_LD_BEN = 0; i_NZP = 3'b000; i_COND_bits = 3'b010; #1;
        chk("s2.ben_branch", 32'(o_AddressNextState), 4);
        step("s2.br");

        // Scenario 3: IRD dispatch and ACV branch
        i_SEQ_op = 2'b01; i_IR_15_9 = 7'b1100_000; i_COND_bits = 3'b110; #1;
        chk("s3.ird", 32'(o_AddressNextState), 12);
        step("s3.ird");
        i_SEQ_op = 2'b00; i_j_field = AW'(3); i_ACV = 1; #1;
        chk("s3.acv", 32'(o_AddressNextState), 35);
        step("s3.acv");
        idle();

        // Scenario 4: nested call/return
        call(40, 7); call(50, 9); ret(); ret();
`ifdef MICROSEQ_CALL_STACK_EN
        chk("s4.upc_after_rets", 32'(o_uPC), 7);
`endif

        // Scenario 5: overflow, then underflow; error is sticky
        for (int k = 0; k < 5; k++) call(10 + k, 20 + k);
`ifdef MICROSEQ_CALL_STACK_EN
        chk("s5.ovf_err", 32'(o_stack_err), 1);
        chk("s5.ovf_depth", 32'(o_stack_depth), SD);
`endif
        for (int k = 0; k < 5; k++) ret();
`ifdef MICROSEQ_CALL_STACK_EN
        chk("s5.unf_upc", 32'(o_uPC), RV);
        chk("s5.unf_err", 32'(o_stack_err), 1);
`endif

        // Scenario 6: stall holds state during a call, reset overrides stall
        idle(); i_RST_N = 0; step("s6.rst");
        idle(); call(33, 5);
        i_STALL = 1;
        for (int k = 0; k < 3; k++) call(44, 6);
        i_RST_N = 0; step("s6.rst_stall");
        chk("s6.upc_reset", 32'(o_uPC), RV);
        idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            i_RST_N     = ($urandom_range(0, 39) != 0);
            i_STALL     = ($urandom_range(0, 7) == 0);
            i_SEQ_op    = 2'($urandom_range(0, 3));
            i_j_field   = AW'($urandom);
            i_ret_field = AW'($urandom);
            i_COND_bits = 3'($urandom);
            i_LD_BEN    = 1'($urandom);
            i_R_Bit     = 1'($urandom);
            i_IR_15_9   = 7'($urandom);
            i_NZP       = 3'($urandom);
            i_ACV       = 1'($urandom);
            i_PSR_15    = 1'($urandom);
            i_INT       = 1'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
